// File: rtl/fetch_sequencer.sv
// Two-word instruction fetch controller: fetches {opcode, operand} over req/ack and issues via valid/ready.
// Optional halt-on-opcode support is enabled by defining FETCH_HALT_EN.
module fetch_sequencer #(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = '1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  ins_valid,
    input  logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] ins_opcode,
    output logic [DATA_WIDTH-1:0] ins_operand,
    output logic [DATA_WIDTH-1:0] ins_pc,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_addr,
    output logic                  halted
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {ST_OP, ST_ARG, ST_ISSUE, ST_HALT} state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   fetch_pc_reg, fetch_pc_next;
    logic            mem_req_reg, mem_req_next;
    logic [DW-1:0]   mem_addr_reg, mem_addr_next;
    logic            ins_valid_reg, ins_valid_next;
    logic [DW-1:0]   ins_opcode_reg, ins_opcode_next;
    logic [DW-1:0]   ins_operand_reg, ins_operand_next;
    logic [DW-1:0]   ins_pc_reg, ins_pc_next;
    logic            halted_reg, halted_next;
    logic [DW-1:0]   opcode_reg, opcode_next;
    logic            pending_reg, pending_next;
    logic [DW-1:0]   pending_addr_reg, pending_addr_next;

    logic            halt_en;
    logic            halt_hit;
    logic            restart;
    logic [DW-1:0]   restart_addr;

`ifdef FETCH_HALT_EN
    assign halt_en = 1'b1;
`else
    assign halt_en = 1'b0;
`endif
    assign halt_hit = halt_en && (mem_rdata == HALT_OPCODE);

    always_comb begin
        state_next        = state_reg;
        fetch_pc_next     = fetch_pc_reg;
        mem_req_next      = mem_req_reg;
        mem_addr_next     = mem_addr_reg;
        ins_valid_next    = ins_valid_reg;
        ins_opcode_next   = ins_opcode_reg;
        ins_operand_next  = ins_operand_reg;
        ins_pc_next       = ins_pc_reg;
        halted_next       = halted_reg;
        opcode_next       = opcode_reg;
        pending_next      = pending_reg;
        pending_addr_next = pending_addr_reg;
        restart           = 1'b0;
        restart_addr      = fetch_pc_reg;

        case (state_reg)
            ST_OP, ST_ARG: begin
                if (!mem_req_reg) begin
                    // Only reachable in the first cycle after reset: start the first request.
                    restart      = 1'b1;
                    restart_addr = redirect_valid ? redirect_addr : fetch_pc_reg;
                end else if (mem_ack) begin
                    if (redirect_valid || pending_reg) begin
                        restart      = 1'b1;
                        restart_addr = redirect_valid ? redirect_addr : pending_addr_reg;
                        pending_next = 1'b0;
                    end else if (state_reg == ST_OP) begin
                        if (halt_hit) begin
                            state_next   = ST_HALT;
                            halted_next  = 1'b1;
                            mem_req_next = 1'b0;
                        end else begin
                            opcode_next   = mem_rdata;
                            state_next    = ST_ARG;
                            mem_addr_next = fetch_pc_reg + DW'(1);
                        end
                    end else begin
                        ins_opcode_next  = opcode_reg;
                        ins_operand_next = mem_rdata;
                        ins_pc_next      = fetch_pc_reg;
                        ins_valid_next   = 1'b1;
                        mem_req_next     = 1'b0;
                        state_next       = ST_ISSUE;
                    end
                end else if (redirect_valid) begin
                    // Outstanding request must complete first; remember the latest target.
                    pending_next      = 1'b1;
                    pending_addr_next = redirect_addr;
                end
            end
            ST_ISSUE: begin
                if (redirect_valid) begin
                    restart        = 1'b1;
                    restart_addr   = redirect_addr;
                    ins_valid_next = 1'b0;
                end else if (ins_ready) begin
                    restart        = 1'b1;
                    restart_addr   = fetch_pc_reg + DW'(2);
                    ins_valid_next = 1'b0;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    restart      = 1'b1;
                    restart_addr = redirect_addr;
                    halted_next  = 1'b0;
                end
            end
            default: state_next = ST_OP;
        endcase

        if (restart) begin
            state_next    = ST_OP;
            fetch_pc_next = restart_addr;
            mem_addr_next = restart_addr;
            mem_req_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_OP;
            fetch_pc_reg     <= RESET_ADDR;
            mem_req_reg      <= 1'b0;
            mem_addr_reg     <= '0;
            ins_valid_reg    <= 1'b0;
            ins_opcode_reg   <= '0;
            ins_operand_reg  <= '0;
            ins_pc_reg       <= '0;
            halted_reg       <= 1'b0;
            opcode_reg       <= '0;
            pending_reg      <= 1'b0;
            pending_addr_reg <= '0;
        end else begin
            state_reg        <= state_next;
            fetch_pc_reg     <= fetch_pc_next;
            mem_req_reg      <= mem_req_next;
            mem_addr_reg     <= mem_addr_next;
            ins_valid_reg    <= ins_valid_next;
            ins_opcode_reg   <= ins_opcode_next;
            ins_operand_reg  <= ins_operand_next;
            ins_pc_reg       <= ins_pc_next;
            halted_reg       <= halted_next;
            opcode_reg       <= opcode_next;
            pending_reg      <= pending_next;
            pending_addr_reg <= pending_addr_next;
        end
    end

    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign ins_valid   = ins_valid_reg;
    assign ins_opcode  = ins_opcode_reg;
    assign ins_operand = ins_operand_reg;
    assign ins_pc      = ins_pc_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; the halt scenario follows FETCH_HALT_EN like the design.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_opcode;
    logic [15:0] ins_operand;
    logic [15:0] ins_pc;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        halted;

    logic [15:0] mem [0:65535];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    fetch_sequencer #(
        .DATA_WIDTH (16),
        .RESET_ADDR (16'h0000),
        .HALT_OPCODE(16'hFFFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .ins_valid     (ins_valid),
        .ins_ready     (ins_ready),
        .ins_opcode    (ins_opcode),
        .ins_operand   (ins_operand),
        .ins_pc        (ins_pc),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .halted        (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [15:0] addr);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, addr});
        chk({tag, "_valid"}, {31'd0, ins_valid}, 32'd0);
    endtask

    task automatic chk_issue(input string tag, input logic [15:0] op, input logic [15:0] arg,
                             input logic [15:0] pc);
        chk({tag, "_valid"}, {31'd0, ins_valid}, 32'd1);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_opcode"}, {16'd0, ins_opcode}, {16'd0, op});
        chk({tag, "_operand"}, {16'd0, ins_operand}, {16'd0, arg});
        chk({tag, "_pc"}, {16'd0, ins_pc}, {16'd0, pc});
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h7000;
        mem[16'h0001] = 16'h0010;
        mem[16'h0002] = 16'h1234;
        mem[16'h0003] = 16'h5678;
        mem[16'h0004] = 16'hFFFF;
        mem[16'h0005] = 16'h0ABC;
        mem[16'h0008] = 16'h2222;
        mem[16'h0009] = 16'h3333;
        mem[16'h0040] = 16'h4444;
        mem[16'h0041] = 16'h5555;
        mem[16'h0100] = 16'h9999;
        mem[16'hFFFE] = 16'hBEEF;
        mem[16'hFFFF] = 16'hCAFE;

        reset          = 1'b1;
        mem_ack        = 1'b0;
        ins_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 16'h0000;
        tick();
        tick();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc", {16'd0, ins_pc}, 32'd0);

        // Scenario 1/2: zero-wait fetch, then execute stalls for 5 cycles
        reset = 1'b0;
        tick();
        chk_fetch("t1_first", 16'h0000);
        mem_ack = 1'b1;
        tick();
        chk_fetch("t1_arg", 16'h0001);
        tick();
        chk_issue("t1_issue", 16'h7000, 16'h0010, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_issue("t2_stall", 16'h7000, 16'h0010, 16'h0000);
        end
        ins_ready = 1'b1;
        tick();
        chk_fetch("t2_next", 16'h0002);
        ins_ready = 1'b0;

        // Scenario 3: three wait cycles on each word
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fetch("t3_op_wait", 16'h0002);
        end
        mem_ack = 1'b1;
        tick();
        chk_fetch("t3_arg", 16'h0003);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fetch("t3_arg_wait", 16'h0003);
        end
        mem_ack = 1'b1;
        tick();
        chk_issue("t3_issue", 16'h1234, 16'h5678, 16'h0002);
        mem_ack   = 1'b0;
        ins_ready = 1'b1;
        tick();
        chk_fetch("t3_next", 16'h0004);
        ins_ready = 1'b0;

`ifdef FETCH_HALT_EN
        // Scenario 6: halt opcode stops fetch until a redirect
        mem_ack = 1'b1;
        tick();
        chk("t6_halted", {31'd0, halted}, 32'd1);
        chk("t6_req", {31'd0, mem_req}, 32'd0);
        chk("t6_valid", {31'd0, ins_valid}, 32'd0);
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t6_hold_req", {31'd0, mem_req}, 32'd0);
            chk("t6_hold_halted", {31'd0, halted}, 32'd1);
        end
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0008;
        tick();
        chk("t6_unhalt", {31'd0, halted}, 32'd0);
        chk_fetch("t6_restart", 16'h0008);
        redirect_valid = 1'b0;
`else
        // Without halt support 0xFFFF is an ordinary opcode
        mem_ack = 1'b1;
        tick();
        chk_fetch("t6_arg", 16'h0005);
        chk("t6_not_halted", {31'd0, halted}, 32'd0);
        tick();
        chk_issue("t6_issue", 16'hFFFF, 16'h0ABC, 16'h0004);
        mem_ack   = 1'b0;
        ins_ready = 1'b1;
        tick();
        chk_fetch("t6_next", 16'h0006);
        ins_ready = 1'b0;
        // Redirect with no ack: request held, then restart at captured target
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0008;
        tick();
        chk_fetch("t6_pend_hold", 16'h0006);
        redirect_valid = 1'b0;
        mem_ack        = 1'b1;
        tick();
        chk_fetch("t6_pend_go", 16'h0008);
        mem_ack = 1'b0;
`endif

        // Scenario 4: redirect in ARG, ack two cycles later
        mem_ack = 1'b1;
        tick();
        chk_fetch("t4_arg", 16'h0009);
        mem_ack        = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0040;
        tick();
        chk_fetch("t4_hold1", 16'h0009);
        redirect_valid = 1'b0;
        tick();
        chk_fetch("t4_hold2", 16'h0009);
        mem_ack = 1'b1;
        tick();
        chk_fetch("t4_redirected", 16'h0040);
        tick();
        chk_fetch("t4_arg2", 16'h0041);
        tick();
        chk_issue("t4_issue", 16'h4444, 16'h5555, 16'h0040);

        // Scenario 5: redirect coinciding with a handshake in ISSUE
        ins_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0100;
        tick();
        chk_fetch("t5_redirect", 16'h0100);
        ins_ready = 1'b0;

        // Redirect in the same cycle as the opcode ack: data dropped
        redirect_addr = 16'hFFFE;
        tick();
        chk_fetch("t5_ack_redirect", 16'hFFFE);
        redirect_valid = 1'b0;

        // Scenario 7: address wrap
        tick();
        chk_fetch("t7_arg", 16'hFFFF);
        tick();
        chk_issue("t7_issue1", 16'hBEEF, 16'hCAFE, 16'hFFFE);
        ins_ready = 1'b1;
        tick();
        chk_fetch("t7_wrap_pc", 16'h0000);
        ins_ready      = 1'b0;
        mem_ack        = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'hFFFF;
        tick();
        chk_fetch("t7_pend", 16'h0000);
        redirect_valid = 1'b0;
        mem_ack        = 1'b1;
        tick();
        chk_fetch("t7_op_ffff", 16'hFFFF);
        tick();
        chk_fetch("t7_wrap_arg", 16'h0000);
        tick();
        chk_issue("t7_issue2", 16'hCAFE, 16'h7000, 16'hFFFF);

        // Reset while an instruction is held, ack still asserted
        reset = 1'b1;
        tick();
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, ins_valid}, 32'd0);
        chk("mid_rst_pc", {16'd0, ins_pc}, 32'd0);
        tick();
        chk("mid_rst_req2", {31'd0, mem_req}, 32'd0);
        reset = 1'b0;
        tick();
        chk_fetch("post_rst", 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
